// File: rtl/yutorina_bus_arbiter_pkg.sv
// Shared types and constants for the four-master bus arbiter.
package yutorina_bus_arbiter_pkg;

    // Bus owner encoding
    localparam int unsigned BUS_OWNER_W = 2;
    localparam logic [BUS_OWNER_W-1:0] BUS_OWNER_M0 = 2'd0;
    localparam logic [BUS_OWNER_W-1:0] BUS_OWNER_M1 = 2'd1;
    localparam logic [BUS_OWNER_W-1:0] BUS_OWNER_M2 = 2'd2;
    localparam logic [BUS_OWNER_W-1:0] BUS_OWNER_M3 = 2'd3;

    // Default tenure limit; 0 disables preemption
    localparam int unsigned BUS_MAX_HOLD = 0;

    // Active-low bus signalling levels
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    typedef enum logic [BUS_OWNER_W-1:0] {
        OWNER0 = BUS_OWNER_M0,
        OWNER1 = BUS_OWNER_M1,
        OWNER2 = BUS_OWNER_M2,
        OWNER3 = BUS_OWNER_M3
    } owner_e;

    // Active-low one-cold grant vector for a given owner, bit i = master i
    function automatic logic [3:0] grant_vec_n(owner_e o);
        return ~(4'b0001 << o);
    endfunction

endpackage

// File: rtl/yutorina_bus_arbiter_if.sv
// Request/grant/strobe bundle between the masters, the bus multiplexer and the arbiter.
interface yutorina_bus_arbiter_if;
    import yutorina_bus_arbiter_pkg::*;

    logic                   m0_req_;
    logic                   m1_req_;
    logic                   m2_req_;
    logic                   m3_req_;
    logic                   s_as_;
    logic                   m0_grnt_;
    logic                   m1_grnt_;
    logic                   m2_grnt_;
    logic                   m3_grnt_;
    logic [BUS_OWNER_W-1:0] owner;

    // Requester / bus side
    modport master (
        output m0_req_, m1_req_, m2_req_, m3_req_, s_as_,
        input  m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, owner
    );

    // Arbiter side
    modport slave (
        input  m0_req_, m1_req_, m2_req_, m3_req_, s_as_,
        output m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, owner
    );

endinterface

// File: rtl/yutorina_rr_pick.sv
// Round-robin selector: first active request after the current owner, wrapping.
module yutorina_rr_pick
    import yutorina_bus_arbiter_pkg::*;
(
    input  logic [3:0] i_req,
    input  owner_e     i_owner,
    output owner_e     o_next,
    output logic       o_found
);

    logic [1:0] w_idx;

    // Scan farthest-to-nearest so the nearest requester after the owner wins
    always_comb begin
        o_next  = i_owner;
        o_found = 1'b0;
        w_idx   = '0;
        for (int k = 3; k >= 0; k--) begin
            w_idx = i_owner + 2'(k);
            if (k != 0 && i_req[w_idx]) begin
                o_next  = owner_e'(w_idx);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/yutorina_bus_arbiter.sv
// Four-master round-robin bus arbiter with optional tenure-limited preemption.
// Ownership is always held by exactly one master; the bus parks on the last owner.
module yutorina_bus_arbiter
    import yutorina_bus_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = BUS_MAX_HOLD,
    parameter int unsigned CNT_W    = 8
) (
    input logic                   clk,
    input logic                   reset_,
    yutorina_bus_arbiter_if.slave io_bus
);

    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

    owner_e           r_owner;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [3:0]       r_grnt_n;

    logic [3:0]       w_req;
    logic [3:0]       w_others;
    logic             w_others_any;
    logic             w_owner_req;
    logic             w_bus_idle;
    logic             w_preempt;
    owner_e           w_pick;
    logic             w_found;
    owner_e           w_owner_d;
    logic [CNT_W-1:0] w_hold_d;

    // Active-high request view, with the owner's own line split out
    always_comb begin
        w_req        = ~{io_bus.m3_req_, io_bus.m2_req_, io_bus.m1_req_, io_bus.m0_req_};
        w_owner_req  = w_req[r_owner];
        w_others     = w_req & ~(4'b0001 << r_owner);
        w_others_any = |w_others;
        w_bus_idle   = (io_bus.s_as_ == DISABLE_);
    end

    yutorina_rr_pick u_rr_pick (
        .i_req   (w_others),
        .i_owner (r_owner),
        .o_next  (w_pick),
        .o_found (w_found)
    );

    // Next owner and tenure count; rotation on release, or forced at an idle bus cycle
    always_comb begin
        w_preempt = (MAX_HOLD != 0) && w_owner_req && w_others_any
                    && (r_hold_cnt == HOLD_MAX) && w_bus_idle;

        w_owner_d = r_owner;
        if ((!w_owner_req || w_preempt) && w_found) begin
            w_owner_d = w_pick;
        end

        w_hold_d = r_hold_cnt;
        if ((w_owner_d != r_owner) || !w_others_any) begin
            w_hold_d = '0;
        end else if ((MAX_HOLD != 0) && (r_hold_cnt != HOLD_MAX)) begin
            w_hold_d = r_hold_cnt + CNT_W'(1);
        end
    end

    // Owner, tenure counter and registered grants; reset parks the bus on master 0
    always_ff @(posedge clk) begin
        if (!reset_) begin
            r_owner    <= owner_e'(BUS_OWNER_M0);
            r_hold_cnt <= '0;
            r_grnt_n   <= grant_vec_n(owner_e'(BUS_OWNER_M0));
        end else begin
            r_owner    <= w_owner_d;
            r_hold_cnt <= w_hold_d;
            r_grnt_n   <= grant_vec_n(w_owner_d);
        end
    end

    // Drive the grant lines and status from the registers
    always_comb begin
        io_bus.m0_grnt_ = r_grnt_n[0];
        io_bus.m1_grnt_ = r_grnt_n[1];
        io_bus.m2_grnt_ = r_grnt_n[2];
        io_bus.m3_grnt_ = r_grnt_n[3];
        io_bus.owner    = r_owner;
    end

endmodule

// File: tb/tb_yutorina_bus_arbiter.sv
// Directed bench: one arbiter with a tenure limit of 4, one with preemption disabled,
// both driven from the same request/strobe lines.
module tb_yutorina_bus_arbiter;
    import yutorina_bus_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       reset_ = 1'b0;
    logic [3:0] req_n = 4'b1111;
    logic       s_as_n = 1'b1;
    int         n_vec = 0;
    int         n_miss = 0;
    logic [3:0] gnt_a;
    logic [3:0] gnt_b;

    yutorina_bus_arbiter_if if_a ();
    yutorina_bus_arbiter_if if_b ();

    assign if_a.m0_req_ = req_n[0];
    assign if_a.m1_req_ = req_n[1];
    assign if_a.m2_req_ = req_n[2];
    assign if_a.m3_req_ = req_n[3];
    assign if_a.s_as_   = s_as_n;
    assign if_b.m0_req_ = req_n[0];
    assign if_b.m1_req_ = req_n[1];
    assign if_b.m2_req_ = req_n[2];
    assign if_b.m3_req_ = req_n[3];
    assign if_b.s_as_   = s_as_n;

    assign gnt_a = {if_a.m3_grnt_, if_a.m2_grnt_, if_a.m1_grnt_, if_a.m0_grnt_};
    assign gnt_b = {if_b.m3_grnt_, if_b.m2_grnt_, if_b.m1_grnt_, if_b.m0_grnt_};

    yutorina_bus_arbiter #(.MAX_HOLD(4), .CNT_W(8)) dut_a (
        .clk    (clk),
        .reset_ (reset_),
        .io_bus (if_a)
    );

    yutorina_bus_arbiter #(.MAX_HOLD(0), .CNT_W(8)) dut_b (
        .clk    (clk),
        .reset_ (reset_),
        .io_bus (if_b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Owner plus the full grant vector implied by it
    task automatic chk_a(input string tag, input int exp_owner);
        logic [3:0] e;
        e = ~(4'b0001 << exp_owner);
        chk({tag, " a.owner"}, int'(if_a.owner), exp_owner);
        chk({tag, " a.grnt"}, int'(gnt_a), int'(e));
    endtask

    task automatic chk_b(input string tag, input int exp_owner);
        logic [3:0] e;
        e = ~(4'b0001 << exp_owner);
        chk({tag, " b.owner"}, int'(if_b.owner), exp_owner);
        chk({tag, " b.grnt"}, int'(gnt_b), int'(e));
    endtask

    task automatic do_reset(input logic [3:0] req_during);
        reset_ = 1'b0;
        req_n  = req_during;
        tick();
        reset_ = 1'b1;
    endtask

    initial begin
        // Reset with every master requesting
        reset_ = 1'b0;
        req_n  = 4'b0000;
        s_as_n = 1'b1;
        tick();
        tick();
        chk_a("reset", 0);
        chk_b("reset", 0);

        // Leave reset with m0 not requesting: m1 is next in order
        reset_ = 1'b1;
        req_n  = 4'b0001;
        tick();
        chk_a("post_reset", 1);
        chk_b("post_reset", 1);

        // Round robin 1,2,3 then back to 0 (m0 keeps requesting)
        do_reset(4'b0000);
        tick();
        chk_a("rr_hold0", 0);
        req_n = 4'b0001;
        tick();
        chk_a("rr_to1", 1);
        req_n = 4'b0000;
        tick();
        chk_a("rr_hold1a", 1);
        tick();
        chk_a("rr_hold1b", 1);
        req_n = 4'b0010;
        tick();
        chk_a("rr_to2", 2);
        chk_b("rr_to2", 2);
        tick();
        tick();
        chk_a("rr_hold2", 2);
        req_n = 4'b0110;
        tick();
        chk_a("rr_to3", 3);
        tick();
        tick();
        chk_a("rr_hold3", 3);
        req_n = 4'b1110;
        tick();
        chk_a("rr_to0", 0);
        chk_b("rr_to0", 0);

        // Park on 2 with nobody requesting, then hand to m1
        req_n = 4'b1011;
        tick();
        chk_a("park_to2", 2);
        req_n = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_a($sformatf("park%0d", i), 2);
        end
        req_n = 4'b1101;
        tick();
        chk_a("park_to1", 1);

        // Preemption: m0 holds, m3 waits, bus idle -> rotation on the 5th edge
        do_reset(4'b1110);
        s_as_n = 1'b1;
        tick();
        chk_a("pre_start", 0);
        req_n = 4'b0110;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk_a($sformatf("preempt%0d", i), (i == 5) ? 3 : 0);
            chk_b($sformatf("preempt%0d", i), 0);
        end

        // Mid-transfer reset returns the grant to master 0
        reset_ = 1'b0;
        tick();
        chk_a("reset_mid", 0);
        reset_ = 1'b1;

        // Preemption blocked by an access in flight, fires once the strobe drops
        do_reset(4'b1110);
        tick();
        req_n  = 4'b0110;
        s_as_n = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk_a($sformatf("blocked%0d", i), 0);
        end
        s_as_n = 1'b1;
        tick();
        chk_a("unblocked", 3);

        // No tenure limit: owner keeps the bus and the counter never moves
        do_reset(4'b0000);
        for (int i = 0; i < 100; i++) begin
            tick();
            chk($sformatf("nohold%0d b.owner", i), int'(if_b.owner), 0);
            chk($sformatf("nohold%0d b.cnt", i), int'(dut_b.r_hold_cnt), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
